// File: rtl/imem_sync.sv
// Writable LEGv8 instruction memory with a registered read (1-cycle latency).
// A stall holds q/q_valid/misalign; an optional post-reset sweep zeroes every word while busy is high.
module imem_sync #(
  parameter int N              = 32,
  parameter int WORDS_AW       = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [WORDS_AW+1:0]   fetch_addr,
  input  logic                  stall,
  output logic [N-1:0]          q,
  output logic                  q_valid,
  output logic                  misalign,
  output logic                  busy,
  input  logic                  prog_we,
  input  logic [WORDS_AW-1:0]   prog_addr,
  input  logic [N-1:0]          prog_data
);

  localparam int DEPTH = 2 ** WORDS_AW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  logic [0:0]          state;
  logic [WORDS_AW-1:0] clr_cnt;
  logic [N-1:0]        mem [DEPTH];

  logic                run;
  logic [WORDS_AW-1:0] fetch_idx;
  logic                mem_we;
  logic [WORDS_AW-1:0] wr_idx;
  logic [N-1:0]        wr_dat;

  assign run       = (state == ST_RUN);
  assign busy      = ~run;
  assign fetch_idx = fetch_addr[WORDS_AW+1:2];

  // The sweep owns the write port while busy; reset gating keeps word 0 untouched while held in reset.
  always_comb begin
    mem_we = 1'b0;
    wr_idx = clr_cnt;
    wr_dat = '0;
    if (reset) begin
      if (run) begin
        mem_we = prog_we;
        wr_idx = prog_addr;
        wr_dat = prog_data;
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state <= ST_RUN;
      end
    end
  end

  // Read sees the pre-write array contents, so a same-cycle write to the fetched word returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q        <= '0;
      q_valid  <= 1'b0;
      misalign <= 1'b0;
    end else if (run && !stall) begin
      if (fetch_req) begin
        q        <= mem[fetch_idx];
        q_valid  <= 1'b1;
        misalign <= |fetch_addr[1:0];
      end else begin
        q_valid  <= 1'b0;
        misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Randomised and directed checks of imem_sync against a word-array reference model.
module tb_imem_sync;

  localparam int N     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW+1:0] fetch_addr;
  logic          stall;
  logic [N-1:0]  q;
  logic          q_valid;
  logic          misalign;
  logic          busy;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [N-1:0]  prog_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] ref_mem [DEPTH];
  logic [N-1:0] ref_q;
  logic         ref_v;
  logic         ref_m;

  always #5 clk = ~clk;

  imem_sync #(.N(N), .WORDS_AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .q(q), .q_valid(q_valid), .misalign(misalign), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    stall      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
  endtask

  // After a reset and a complete sweep the memory reads as all zeros.
  task automatic model_reset();
    ref_q = '0;
    ref_v = 1'b0;
    ref_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One RUN-mode cycle: apply inputs, advance the model, clock, and land 1 ns after the edge.
  task automatic drive(input logic f, input logic [7:0] a, input logic s,
                       input logic we, input logic [5:0] pa, input logic [31:0] pd);
    fetch_req  = f;
    fetch_addr = a;
    stall      = s;
    prog_we    = we;
    prog_addr  = pa;
    prog_data  = pd;
    if (!s) begin
      if (f) begin
        ref_q = ref_mem[a[7:2]];
        ref_v = 1'b1;
        ref_m = (a[1:0] != 2'b00);
      end else begin
        ref_v = 1'b0;
        ref_m = 1'b0;
      end
    end
    if (we) ref_mem[pa] = pd;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Releases reset just after an edge and counts busy cycles, hammering the ignored ports meanwhile.
  task automatic release_and_sweep(input string name);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = 8'($urandom_range(0, 255));
      prog_we    = 1'($urandom_range(0, 1));
      prog_addr  = 6'($urandom_range(0, 63));
      prog_data  = $urandom;
      @(posedge clk);
      #1;
      n++;
      vectors++;
      if (q_valid !== 1'b0 || q !== '0 || misalign !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busy_outputs cycle %0d: q=%h q_valid=%b misalign=%b, required 0/0/0",
                 name, n, q, q_valid, misalign);
      end
    end
    idle_inputs();
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL %s_busy_len: busy lasted %0d cycles, required %0d", name, n, DEPTH);
    end
    model_reset();
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b0;
    #12;
    vectors++;
    if (q !== '0 || q_valid !== 1'b0 || misalign !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: q=%h q_valid=%b misalign=%b busy=%b, required 0/0/0/1",
               q, q_valid, misalign, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != DEPTH) begin
      miscompares++;
      $display("FAIL reset_busy_len: busy lasted %0d cycles, required %0d", n, DEPTH);
    end
    model_reset();
  endtask

  task automatic test_clear_readback();
    logic [7:0] addrs [3];
    addrs[0] = 8'h00;
    addrs[1] = 8'h7C;
    addrs[2] = 8'hFC;
    foreach (addrs[i]) begin
      drive(1'b1, addrs[i], 1'b0, 1'b0, 6'd0, 32'd0);
      vectors++;
      if (q !== 32'd0 || q_valid !== 1'b1 || misalign !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_read_%h: q=%h q_valid=%b misalign=%b, required 0/1/0",
                 addrs[i], q, q_valid, misalign);
      end
    end
  endtask

  task automatic test_write_fetch();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 6'd0, 32'hf8000001);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 6'd3, 32'h8b050083);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'hf8000001 || q_valid !== 1'b1 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL write_fetch_idx0: q=%h q_valid=%b misalign=%b, required f8000001/1/0",
               q, q_valid, misalign);
    end
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'h8b050083 || q_valid !== 1'b1 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL write_fetch_idx3: q=%h q_valid=%b misalign=%b, required 8b050083/1/0",
               q, q_valid, misalign);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'h8b050083 || q_valid !== 1'b0 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: q=%h q_valid=%b misalign=%b, required 8b050083/0/0",
               q, q_valid, misalign);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 8'h0E, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'h8b050083 || q_valid !== 1'b1 || misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_0E: q=%h q_valid=%b misalign=%b, required 8b050083/1/1",
               q, q_valid, misalign);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h0C, 1'b1, 1'b0, 6'd0, 32'd0);
      vectors++;
      if (q !== 32'hf8000001 || q_valid !== 1'b1 || misalign !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: q=%h q_valid=%b misalign=%b, required f8000001/1/0",
                 i, q, q_valid, misalign);
      end
    end
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'h8b050083 || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: q=%h q_valid=%b, required 8b050083/1", q, q_valid);
    end
  endtask

  task automatic test_rw_collision();
    drive(1'b1, 8'h14, 1'b0, 1'b1, 6'd5, 32'hb400001f);
    vectors++;
    if (q !== 32'd0 || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_old: q=%h q_valid=%b, required 00000000/1", q, q_valid);
    end
    drive(1'b1, 8'h14, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'hb400001f) begin
      miscompares++;
      $display("FAIL collision_new: q=%h, required b400001f", q);
    end
  endtask

  task automatic test_reset_mid_fetch();
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'h8b050083 || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midfetch_pre: q=%h q_valid=%b, required 8b050083/1", q, q_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (q !== '0 || q_valid !== 1'b0 || misalign !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midfetch_async: q=%h q_valid=%b misalign=%b busy=%b, required 0/0/0/1",
               q, q_valid, misalign, busy);
    end
    release_and_sweep("midfetch");
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (q !== 32'd0 || q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midfetch_cleared: q=%h q_valid=%b, required 0/1", q, q_valid);
    end
  endtask

  task automatic test_random();
    logic         f, s, we;
    logic [7:0]   a;
    logic [5:0]   pa;
    logic [31:0]  pd;
    for (int i = 0; i < 400; i++) begin
      f  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      we = ($urandom_range(0, 2) == 0);
      pd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a  = 8'($urandom_range(0, 255));
        pa = 6'($urandom_range(0, 63));
      end else begin
        a  = 8'($urandom_range(0, 31));
        pa = 6'($urandom_range(0, 7));
      end
      drive(f, a, s, we, pa, pd);
      vectors++;
      if (q !== ref_q || q_valid !== ref_v || misalign !== ref_m) begin
        miscompares++;
        $display("FAIL random_%0d: q=%h q_valid=%b misalign=%b, required %h/%b/%b",
                 i, q, q_valid, misalign, ref_q, ref_v, ref_m);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (q !== '0 || q_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midclear_async: q=%h q_valid=%b busy=%b, required 0/0/1", q, q_valid, busy);
    end
    release_and_sweep("midclear");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i * 4), 1'b0, 1'b0, 6'd0, 32'd0);
      vectors++;
      if (q !== ref_q || q_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL midclear_scan_%0d: q=%h q_valid=%b, required %h/1", i, q, q_valid, ref_q);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_clear_readback();
    test_write_fetch();
    test_misalign();
    test_stall();
    test_rw_collision();
    test_reset_mid_fetch();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
